// File: rtl/teclado_codigo_pkg.sv
// Shared parking-system definitions: keypad codes, FSM encodings and counter width.
package teclado_codigo_pkg;

  localparam int CNT_W = 16;

  localparam logic [3:0] TECLA_BORRAR    = 4'hA;
  localparam logic [3:0] TECLA_CONFIRMAR = 4'hB;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DIGIT1    = 3'd1,
    READY     = 3'd2,
    SEND      = 3'd3,
    WAIT_RESP = 3'd4,
    LOCKED    = 3'd5
  } estado_t;

  function automatic logic es_digito(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/teclado_codigo_contador_timeout.sv
// Saturating 16-bit up-counter; tc flags the cycle that completes LIMIT counted cycles.
module contador_timeout
  import teclado_codigo_pkg::*;
#(
  parameter int LIMIT = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W:0] LIM = LIMIT[CNT_W:0];

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Compare count+1 so the current cycle is included and LIMIT=0 cannot underflow.
  assign tc = ({1'b0, count} + 1'b1) >= LIM;

endmodule

// File: rtl/teclado_codigo.sv
// Two-digit keypad entry: collects a BCD code, hands it to the gate controller and
// waits for its verdict, with inactivity/response timeouts and a lock override.
//
// state     | meaning
// IDLE      | no digits held
// DIGIT1    | first digit held
// READY     | two digits held, waiting for confirmar
// SEND      | one-cycle sEnter strobe
// WAIT_RESP | waiting for sAbrir/sAlmInc or response timeout
// LOCKED    | controller blocked, keys ignored
module teclado_codigo
  import teclado_codigo_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int RESP_TO = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tecla_valida,
  input  logic [3:0] tecla,
  input  logic       sAbrir,
  input  logic       sAlmInc,
  input  logic       sBloq,
  output logic [7:0] sCode,
  output logic       sEnter,
  output logic [1:0] nDigitos,
  output logic       ocupado,
  output logic       bloqueado
);

  estado_t state, next_state;

  logic key_digit, key_borrar, key_conf;
  logic inact_tc, resp_tc, cnt_clr;
  logic [7:0] code_nxt;
  logic [1:0] ndig_nxt;

  assign key_digit  = tecla_valida && es_digito(tecla);
  assign key_borrar = tecla_valida && (tecla == TECLA_BORRAR);
  assign key_conf   = tecla_valida && (tecla == TECLA_CONFIRMAR);

  // Every accepted key changes state, so one clear covers both counters.
  assign cnt_clr = (next_state != state);

  contador_timeout #(.LIMIT(TIMEOUT)) u_inact (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clr),
    .enable ((state == DIGIT1) || (state == READY)),
    .tc     (inact_tc)
  );

  contador_timeout #(.LIMIT(RESP_TO)) u_resp (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clr),
    .enable (state == WAIT_RESP),
    .tc     (resp_tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sCode     <= 8'h00;
      sEnter    <= 1'b0;
      nDigitos  <= 2'd0;
      ocupado   <= 1'b0;
      bloqueado <= 1'b0;
    end else begin
      state     <= next_state;
      sCode     <= code_nxt;
      sEnter    <= (next_state == SEND);
      nDigitos  <= ndig_nxt;
      ocupado   <= (next_state != IDLE);
      bloqueado <= (next_state == LOCKED);
    end
  end

  always_comb begin
    next_state = state;
    if (sBloq) begin
      next_state = LOCKED;
    end else begin
      case (state)
        IDLE:      if (key_digit) next_state = DIGIT1;
        DIGIT1: begin
          if (key_digit)       next_state = READY;
          else if (key_borrar) next_state = IDLE;
          else if (inact_tc)   next_state = IDLE;
        end
        READY: begin
          if (key_conf)        next_state = SEND;
          else if (key_borrar) next_state = IDLE;
          else if (inact_tc)   next_state = IDLE;
        end
        SEND:      next_state = WAIT_RESP;
        WAIT_RESP: if (sAbrir || sAlmInc || resp_tc) next_state = IDLE;
        LOCKED:    next_state = IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    code_nxt = sCode;
    ndig_nxt = 2'd0;
    case (next_state)
      IDLE, LOCKED: code_nxt = 8'h00;
      DIGIT1: begin
        ndig_nxt = 2'd1;
        if (state == IDLE) code_nxt = {4'h0, tecla};
      end
      READY: begin
        ndig_nxt = 2'd2;
        if (state == DIGIT1) code_nxt = {sCode[3:0], tecla};
      end
      SEND, WAIT_RESP: ndig_nxt = 2'd2;
      default: code_nxt = 8'h00;
    endcase
  end

endmodule
